incr_result_fifo: RTL and testbench
===================================

# incr_result_fifo

Downstream buffering stage for the increment stage's output stream (`data_out`/`valid`, value = input + 1). It captures every valid result word into a small first-word-fall-through FIFO and re-presents it on a ready/valid interface so a slower consumer can drain it. It also keeps a count of accepted words and a sticky overflow flag. The increment stage has no backpressure, so words arriving while the FIFO is full are dropped and flagged.

## Interface
- `DATA_W`, default 8: result word width.
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `CNT_W`, default 16: width of the accepted-word counter.

Ports:
- `clk`, input, 1: single clock; all state updates on posedge.
- `reset_n`, input, 1: asynchronous active-low reset.
- `in_data`, input, DATA_W: result word from the increment stage.
- `in_valid`, input, 1: `in_data` is valid this cycle. No ready is returned upstream.
- `out_data`, output, DATA_W: head-of-FIFO word; 0 when `out_valid`=0.
- `out_valid`, output, 1: FIFO non-empty.
- `out_ready`, input, 1: consumer accepts `out_data` this cycle.
- `level`, output, $clog2(DEPTH+1): current occupancy, 0..DEPTH.
- `overflow`, output, 1: sticky; set when a word is dropped.
- `accept_cnt`, output, CNT_W: number of words written since reset, wrapping.

## Operation
- Storage: DEPTH×DATA_W register array, with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Occupancy is held in `level`.
- pop = `out_valid` & `out_ready`.
- push = `in_valid` & (`level` < DEPTH | pop).
- drop = `in_valid` & (`level` == DEPTH) & !pop.
- push: write `in_data` at wptr, wptr+1, `accept_cnt`+1.
- pop: rptr+1.
- `level` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- drop: word discarded; `overflow` ← 1 and stays 1 until reset. No other state changes.
- When full, a simultaneous push and pop is legal. The new word is written into the slot freed by the pop; `level` stays DEPTH and there is no overflow.
- When empty, pop cannot occur because `out_valid`=0. Any `in_valid` is pushed.
- `out_data` = mem[rptr] when `level`≠0, else 0 (combinational mask).
- `out_valid` = (`level` != 0), derived from registered `level`.
- `accept_cnt` wraps from 2^CNT_W−1 to 0 with no flag. Dropped words are not counted.
- Data is passed unmodified; no arithmetic on `in_data`.
- Reset (async assert, removal synchronous to `clk`) clears pointers, `level`=0, `out_valid`=0, `out_data`=0, `overflow`=0, `accept_cnt`=0. Array contents need not be cleared.
- Reset asserted mid-stream discards all buffered words immediately. No word is presented after reset until a new `in_valid`.

## Timing
- Latency from input to output is 1 cycle. A word pushed at edge N appears on `out_data`/`out_valid` after edge N when the FIFO was empty.
- Throughput is 1 word/cycle sustained when `out_ready`=1.
- `out_valid` and `out_data` depend only on registers. No combinational path from `in_*` or `out_ready` to any output.
- `level`, `overflow` and `accept_cnt` reflect the edge at which the event was sampled. They are visible in the following cycle.
- `in_valid` and `in_data` are sampled at posedge. The upstream stage drives them with output skew after the edge, so setup is met within the cycle.

## Test plan
- Reset check: hold `reset_n`=0 for 2 cycles. Required: `out_valid`=0, `out_data`=0, `level`=0, `overflow`=0, `accept_cnt`=0. Then release.
- Streaming: `out_ready`=1, push 8'hA6, 8'h5B, 8'h00 on consecutive cycles. Required: the same values appear on `out_data` one cycle later each, `level` never exceeds 1, and `accept_cnt`=3.
- Fill and overflow: `out_ready`=0, push 8'h01..8'h05. Required: `level`=4, `overflow`=1 after the 5th, `accept_cnt`=4. Then drain with `out_ready`=1; required output is 01,02,03,04 and 05 is absent.
- Full with simultaneous push and pop: fill with 10,11,12,13, then `in_valid`=1 with 8'h14 and `out_ready`=1 in the same cycle. Required: `level` stays 4, `overflow` stays 0, and the drain order is 11,12,13,14.
- Pointer wrap: push and pop 10 words 8'h20..8'h29 through DEPTH=4 with alternating `out_ready`. Required: in-order output and `level` returns to 0.
- Mid-operation reset: with `level`=3, pulse `reset_n` low asynchronously between edges. Required: `out_valid`=0 immediately. After release, a push of 8'h77 appears alone with `level`=1.

Source files
------------

// File: rtl/incr_result_fifo_if.sv
// Ready/valid stream bundle between the increment stage, the result FIFO and its consumer.
// The upstream half (in_*) carries no ready; the downstream half is a full handshake.
interface incr_result_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/incr_result_fifo.sv
// First-word-fall-through buffer for the increment stage's result stream.
// It counts accepted words and raises a sticky flag when a word is dropped because the FIFO is full.
module incr_result_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    incr_result_fifo_if.slave bus,
    output logic [LVL_W-1:0] level,
    output logic             overflow,
    output logic [CNT_W-1:0] accept_cnt
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic              full, pop, push, drop;

    always_comb begin
        full = (level == LVL_W'(DEPTH));
        pop  = bus.out_valid & bus.out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push = bus.in_valid & (~full | pop);
        drop = bus.in_valid & full & ~pop;
    end

    assign bus.out_valid = (level != '0);
    assign bus.out_data  = bus.out_valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            accept_cnt <= '0;
        end else begin
            if (push) begin
                wptr       <= wptr + 1'b1;
                accept_cnt <= accept_cnt + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_incr_result_fifo.sv
// Directed bench for incr_result_fifo: reset, streaming, overflow, full push+pop, pointer wrap, mid-stream reset.
module tb_incr_result_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic [CNT_W-1:0] accept_cnt;

    int tests  = 0;
    int failed = 0;

    incr_result_fifo_if #(.DATA_W(DATA_W)) bus ();

    incr_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .level      (level),
        .overflow   (overflow),
        .accept_cnt (accept_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    logic [DATA_W-1:0] q[$];
    logic              m_pop;
    int                sent;

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_accept_cnt", 32'(accept_cnt), 0);
        reset_n = 1'b1;

        // Streaming, one cycle latency, level never above 1
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA6;
        step();
        chk("stream_a6", 32'(bus.out_data), 32'hA6);
        chk("stream_valid", 32'(bus.out_valid), 1);
        chk("stream_lvl1", 32'(level), 1);
        bus.in_data = 8'h5B;
        step();
        chk("stream_5b", 32'(bus.out_data), 32'h5B);
        chk("stream_lvl2", 32'(level), 1);
        bus.in_data = 8'h00;
        step();
        chk("stream_00", 32'(bus.out_data), 32'h00);
        chk("stream_valid_00", 32'(bus.out_valid), 1);
        chk("stream_lvl3", 32'(level), 1);
        bus.in_valid = 1'b0;
        step();
        chk("stream_empty", 32'(bus.out_valid), 0);
        chk("stream_cnt", 32'(accept_cnt), 3);

        // Fill and overflow
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            step();
            if (i <= 4) begin
                chk("fill_level", 32'(level), 32'(i));
                chk("fill_no_ovf", 32'(overflow), 0);
            end
        end
        bus.in_valid = 1'b0;
        chk("ovf_level", 32'(level), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_cnt", 32'(accept_cnt), 4);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", 32'(bus.out_data), 32'(i));
            step();
        end
        chk("drain_empty", 32'(bus.out_valid), 0);
        chk("drain_data0", 32'(bus.out_data), 0);
        chk("drain_ovf_sticky", 32'(overflow), 1);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h10 + 8'(i);
            step();
        end
        chk("full_level", 32'(level), 4);
        bus.in_data   = 8'h14;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("pp_level", 32'(level), 4);
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_cnt", 32'(accept_cnt), 5);
        for (int i = 1; i <= 4; i++) begin
            chk("pp_drain", 32'(bus.out_data), 32'h10 + 32'(i));
            step();
        end
        chk("pp_empty", 32'(level), 0);

        // Pointer wrap with a small queue model
        sent = 0;
        q.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus.in_valid  = (cyc % 2 == 0) && (sent < 10);
            bus.in_data   = 8'h20 + 8'(sent);
            bus.out_ready = cyc[1];
            chk("wrap_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            chk("wrap_data", 32'(bus.out_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
            chk("wrap_level", 32'(level), 32'(q.size()));
            m_pop = (q.size() != 0) && bus.out_ready;
            if (bus.in_valid && (q.size() < DEPTH || m_pop)) begin
                q.push_back(bus.in_data);
                sent++;
            end
            if (m_pop) void'(q.pop_front());
            step();
        end
        bus.in_valid = 1'b0;
        chk("wrap_all_sent", 32'(sent), 10);
        chk("wrap_end_level", 32'(level), 0);
        chk("wrap_no_ovf", 32'(overflow), 0);

        // Mid-operation asynchronous reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h30 + 8'(i);
            step();
        end
        bus.in_valid = 1'b0;
        chk("mid_level3", 32'(level), 3);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_data", 32'(bus.out_data), 0);
        chk("mid_rst_level", 32'(level), 0);
        #2 reset_n = 1'b1;
        step();
        chk("mid_idle_valid", 32'(bus.out_valid), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        step();
        bus.in_valid = 1'b0;
        chk("mid_77_data", 32'(bus.out_data), 32'h77);
        chk("mid_77_level", 32'(level), 1);
        chk("mid_77_cnt", 32'(accept_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
